// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
//  Shared definitions for the decode-stage hazard scoreboard:
//   - stall cause encodings reported to the pipeline and perf monitor
//   - default producer latency limit and countdown width
//   - latency clamp helper, used so an illegal latency can never load a
//     value the counter cannot represent or that never drains
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

   // Why ID stalled. Encodings are fixed because the perf monitor decodes them.
   typedef enum logic [1:0] {
      HZ_NONE = 2'd0,
      HZ_RAW  = 2'd1,
      HZ_BR   = 2'd2,
      HZ_WAW  = 2'd3
   } hz_cause_e;

   // Longest producer (mul/div) latency and the counter width that holds it.
   localparam int HZ_DEF_MAX_LAT = 4;
   localparam int HZ_DEF_CW      = 3;

   // Latency of 0 would mark a write as already forwardable, and anything
   // above the limit could exceed the counter or violate the WAW ordering
   // assumptions, so both collapse to the slowest legal latency.
   function automatic int hz_clamp_lat(input int lat, input int max_lat);
      if ((lat < 1) || (lat > max_lat)) begin
         return max_lat;
      end
      return lat;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_entry
//  One countdown slice of the scoreboard: the number of cycles until the
//  pending result of a single architectural register can be forwarded to EX.
//  Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active high; clears the countdown
//   hold      in   pipeline freeze; countdown neither loads nor decrements
//   load      in   a new producer for this register issues this cycle
//   load_val  in   latency of that producer (already clamped)
//   cnt       out  current countdown value
//   nz        out  countdown is nonzero (register has a result in flight)
// ---------------------------------------------------------------------------
module hazard_scoreboard_entry
   import hazard_scoreboard_pkg::*;
#(
   parameter int CW = HZ_DEF_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hold,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] cnt,
   output logic          nz
);

   // A fresh producer wins over the decrement: the newest write is the one
   // the next consumer must wait for.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!hold) begin
         if (load) begin
            cnt <= load_val;
         end else if (nz) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   assign nz = |cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//  Decode-stage hazard unit. Keeps a per-register countdown of cycles until
//  each in-flight result reaches the forwarding network, so multi-cycle
//  producers (loads, mul/div) are covered, and stalls ID/IF when the
//  instruction in ID would read or overwrite a register too early. Also keeps
//  a saturating count of stall cycles for the performance monitor.
//  Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   id_valid, id_kill   ID holds a real instruction / it is being squashed
//   hold                global pipeline freeze (scoreboard and counter freeze)
//   id_rs, id_rt        source register indices
//   id_use_rs/rt        the corresponding source is actually read
//   id_uncertainJump    branch/jump-register resolved in ID, operands needed now
//   id_regWrite, id_rw  instruction writes register id_rw
//   id_lat              producer latency, 1..MAX_LAT
//   stall               hold IF/ID and inject a bubble into EX
//   stall_cause         none / RAW / branch operand / WAW
//   busy                per-register "result in flight" flags
//   stall_cycles        saturating count of stalled, unfrozen cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NREG    = 32,
   parameter int MAX_LAT = HZ_DEF_MAX_LAT,
   parameter int CW      = HZ_DEF_CW,
   parameter int PCW     = 16,
   localparam int RW     = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic            id_kill,
   input  logic            hold,
   input  logic [RW-1:0]   id_rs,
   input  logic [RW-1:0]   id_rt,
   input  logic            id_use_rs,
   input  logic            id_use_rt,
   input  logic            id_uncertainJump,
   input  logic            id_regWrite,
   input  logic [RW-1:0]   id_rw,
   input  logic [CW-1:0]   id_lat,
   output logic            stall,
   output logic [1:0]      stall_cause,
   output logic [NREG-1:0] busy,
   output logic [PCW-1:0]  stall_cycles
);

   logic [CW-1:0] cnt [NREG];
   logic [CW-1:0] cnt_rs;
   logic [CW-1:0] cnt_rt;
   logic [CW-1:0] cnt_rw;
   logic [CW-1:0] lat_eff;
   logic          chk_rs;
   logic          chk_rt;
   logic          br_haz;
   logic          raw_haz;
   logic          waw_haz;
   logic          issue;
   hz_cause_e     cause;

   // Register 0 is constant zero: it is never pending and never stalls.
   assign cnt[0]  = '0;
   assign busy[0] = 1'b0;

   assign lat_eff = CW'(hz_clamp_lat(int'(id_lat), MAX_LAT));

   // Source muxes and hazard compare. A source only matters when it is read
   // and is not r0. A branch resolved in ID needs the value already forwarded
   // (count 0); an EX consumer can take it from the forwarding path once the
   // count is down to 1. A new write must not complete before an older
   // in-flight write to the same register, hence the WAW latency compare.
   always_comb begin
      cnt_rs  = cnt[id_rs];
      cnt_rt  = cnt[id_rt];
      cnt_rw  = cnt[id_rw];
      chk_rs  = id_use_rs && (id_rs != '0);
      chk_rt  = id_use_rt && (id_rt != '0);
      br_haz  = id_uncertainJump &&
                ((chk_rs && (cnt_rs != '0)) || (chk_rt && (cnt_rt != '0)));
      raw_haz = (chk_rs && (cnt_rs > CW'(1))) || (chk_rt && (cnt_rt > CW'(1)));
      waw_haz = id_regWrite && (id_rw != '0) && (cnt_rw > lat_eff);
   end

   // Stall is combinational so ID is held in the same cycle the hazard is
   // seen. Cause priority: branch operand, then RAW, then WAW.
   always_comb begin
      stall = id_valid && !id_kill && (br_haz || raw_haz || waw_haz);
      cause = HZ_NONE;
      if (stall) begin
         if (br_haz) begin
            cause = HZ_BR;
         end else if (raw_haz) begin
            cause = HZ_RAW;
         end else begin
            cause = HZ_WAW;
         end
      end
   end

   assign stall_cause = cause;

   // Only an instruction that actually leaves ID may claim its destination.
   assign issue = id_valid && !id_kill && !stall && !hold;

   // One countdown slice per writable register.
   for (genvar r = 1; r < NREG; r++) begin : g_entry
      hazard_scoreboard_entry #(
         .CW(CW)
      ) u_entry (
         .clk      (clk),
         .rst      (rst),
         .hold     (hold),
         .load     (issue && id_regWrite && (id_rw == RW'(r))),
         .load_val (lat_eff),
         .cnt      (cnt[r]),
         .nz       (busy[r])
      );
   end

   // Perf counter: counts cycles that really cost a bubble (a frozen pipeline
   // is charged elsewhere) and sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (stall && !hold && (stall_cycles != {PCW{1'b1}})) begin
         stall_cycles <= stall_cycles + PCW'(1);
      end
   end

   // Illegal producer latencies are clamped in hardware but flagged here.
   a_lat_legal: assert property (@(posedge clk) disable iff (rst)
      (id_valid && !id_kill && id_regWrite) |->
         ((id_lat != '0) && (int'(id_lat) <= MAX_LAT)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//  Directed bench for the hazard scoreboard. A second instance with a 4-bit
//  perf counter shares all inputs to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   localparam int NREG = 32;
   localparam int RW   = 5;
   localparam int CW   = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            id_valid, id_kill, hold;
   logic [RW-1:0]   id_rs, id_rt, id_rw;
   logic            id_use_rs, id_use_rt, id_uncertainJump, id_regWrite;
   logic [CW-1:0]   id_lat;
   logic            stall, stall_s;
   logic [1:0]      stall_cause, stall_cause_s;
   logic [NREG-1:0] busy, busy_s;
   logic [15:0]     stall_cycles;
   logic [3:0]      stall_cycles_s;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NREG(NREG), .MAX_LAT(4), .CW(CW), .PCW(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill), .hold(hold),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_uncertainJump(id_uncertainJump), .id_regWrite(id_regWrite), .id_rw(id_rw),
      .id_lat(id_lat), .stall(stall), .stall_cause(stall_cause), .busy(busy),
      .stall_cycles(stall_cycles));

   hazard_scoreboard #(.NREG(NREG), .MAX_LAT(4), .CW(CW), .PCW(4)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill), .hold(hold),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_uncertainJump(id_uncertainJump), .id_regWrite(id_regWrite), .id_rw(id_rw),
      .id_lat(id_lat), .stall(stall_s), .stall_cause(stall_cause_s), .busy(busy_s),
      .stall_cycles(stall_cycles_s));

   // Empty ID slot.
   task automatic idle();
      id_valid = 1'b0; id_kill = 1'b0; hold = 1'b0;
      id_rs = '0; id_rt = '0; id_rw = '0; id_lat = '0;
      id_use_rs = 1'b0; id_use_rt = 1'b0; id_uncertainJump = 1'b0; id_regWrite = 1'b0;
   endtask

   // Present a valid instruction in ID.
   task automatic set_op(input logic [RW-1:0] rs, input logic use_rs,
                         input logic [RW-1:0] rt, input logic use_rt,
                         input logic jump, input logic wr,
                         input logic [RW-1:0] rw, input logic [CW-1:0] lat);
      id_valid = 1'b1; id_kill = 1'b0; hold = 1'b0;
      id_rs = rs; id_use_rs = use_rs; id_rt = rt; id_use_rt = use_rt;
      id_uncertainJump = jump; id_regWrite = wr; id_rw = rw; id_lat = lat;
   endtask

   // Reset values, then an async reset that lands mid-countdown.
   task automatic test_reset();
      #1;
      checks++; if (busy !== '0) begin fails++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
      checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall); end
      checks++; if (stall_cause !== 2'd0) begin fails++; $display("[TB] FAIL reset_cause: got %0d expected 0", stall_cause); end
      checks++; if (stall_cycles !== 16'd0) begin fails++; $display("[TB] FAIL reset_perf: got %0d expected 0", stall_cycles); end
      @(negedge clk);
      set_op(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 3'd3);
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_prod_stall: got %0b expected 0", stall); end
      @(negedge clk);
      set_op(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0);
      #1;
      checks++; if (busy !== 32'h0000_0020) begin fails++; $display("[TB] FAIL reset_busy5: got %0h expected 20", busy); end
      checks++; if (stall !== 1'b1 || stall_cause !== HZ_RAW) begin fails++; $display("[TB] FAIL reset_pre_stall: got %0b/%0d expected 1/1", stall, stall_cause); end
      @(negedge clk);
      #1;
      checks++; if (stall_cycles !== 16'd1) begin fails++; $display("[TB] FAIL reset_pre_perf: got %0d expected 1", stall_cycles); end
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== '0) begin fails++; $display("[TB] FAIL reset_async_busy: got %0h expected 0", busy); end
      checks++; if (stall !== 1'b0 || stall_cause !== 2'd0) begin fails++; $display("[TB] FAIL reset_async_stall: got %0b/%0d expected 0/0", stall, stall_cause); end
      checks++; if (stall_cycles !== 16'd0) begin fails++; $display("[TB] FAIL reset_async_perf: got %0d expected 0", stall_cycles); end
      @(negedge clk);
      rst = 1'b0;
      idle();
   endtask

   // Load (lat 2) followed by a dependent ALU op: exactly one bubble.
   task automatic test_load_use();
      set_op(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 3'd2);
      @(negedge clk);
      set_op(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 3'd1);
      #1;
      checks++; if (stall !== 1'b1 || stall_cause !== HZ_RAW) begin fails++; $display("[TB] FAIL load_use_stall: got %0b/%0d expected 1/1", stall, stall_cause); end
      @(negedge clk);
      #1;
      checks++; if (stall !== 1'b0 || stall_cause !== HZ_NONE) begin fails++; $display("[TB] FAIL load_use_release: got %0b/%0d expected 0/0", stall, stall_cause); end
      @(negedge clk);
      #1;
      checks++; if (busy !== 32'h0000_0400) begin fails++; $display("[TB] FAIL load_use_busy: got %0h expected 400", busy); end
      idle();
   endtask

   // ALU -> branch costs one bubble; load -> branch costs two.
   task automatic test_branch();
      set_op(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 3'd1);
      @(negedge clk);
      set_op(5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0);
      #1;
      checks++; if (stall !== 1'b1 || stall_cause !== HZ_BR) begin fails++; $display("[TB] FAIL br_alu_stall: got %0b/%0d expected 1/2", stall, stall_cause); end
      @(negedge clk);
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL br_alu_release: got %0b expected 0", stall); end
      @(negedge clk);
      set_op(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 3'd2);
      @(negedge clk);
      set_op(5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 3'd0);
      #1;
      checks++; if (stall !== 1'b1 || stall_cause !== HZ_BR) begin fails++; $display("[TB] FAIL br_load_stall1: got %0b/%0d expected 1/2", stall, stall_cause); end
      @(negedge clk);
      #1;
      checks++; if (stall !== 1'b1 || stall_cause !== HZ_BR) begin fails++; $display("[TB] FAIL br_load_stall2: got %0b/%0d expected 1/2", stall, stall_cause); end
      @(negedge clk);
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL br_load_release: got %0b expected 0", stall); end
      @(negedge clk);
      idle();
   endtask

   // WAW against a lat-4 mul/div, then writes to r0.
   task automatic test_waw_r0();
      set_op(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 3'd4);
      @(negedge clk);
      set_op(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 3'd1);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (stall !== 1'b1 || stall_cause !== HZ_WAW) begin fails++; $display("[TB] FAIL waw_stall%0d: got %0b/%0d expected 1/3", i, stall, stall_cause); end
         @(negedge clk);
      end
      #1;
      checks++; if (stall !== 1'b0 || stall_cause !== HZ_NONE) begin fails++; $display("[TB] FAIL waw_release: got %0b/%0d expected 0/0", stall, stall_cause); end
      @(negedge clk);
      set_op(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 3'd4);
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL r0_write_stall: got %0b expected 0", stall); end
      @(negedge clk);
      set_op(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 3'd1);
      #1;
      checks++; if (busy !== '0) begin fails++; $display("[TB] FAIL r0_busy: got %0h expected 0", busy); end
      checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL r0_read_stall: got %0b expected 0", stall); end
      @(negedge clk);
      idle();
   endtask

   // Hold freezes countdown and perf counter; killed writers change nothing.
   task automatic test_hold_kill();
      rst = 1'b1;
      #1 rst = 1'b0;
      set_op(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 3'd2);
      @(negedge clk);
      set_op(5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0);
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (stall !== 1'b1 || stall_cause !== HZ_RAW) begin fails++; $display("[TB] FAIL hold_stall%0d: got %0b/%0d expected 1/1", i, stall, stall_cause); end
         @(negedge clk);
      end
      #1;
      checks++; if (stall_cycles !== 16'd0) begin fails++; $display("[TB] FAIL hold_perf: got %0d expected 0", stall_cycles); end
      checks++; if (busy !== 32'h0000_0200) begin fails++; $display("[TB] FAIL hold_busy: got %0h expected 200", busy); end
      hold = 1'b0;
      #1;
      checks++; if (stall !== 1'b1) begin fails++; $display("[TB] FAIL hold_cnt_kept: got %0b expected 1", stall); end
      @(negedge clk);
      #1;
      checks++; if (stall_cycles !== 16'd1) begin fails++; $display("[TB] FAIL unhold_perf: got %0d expected 1", stall_cycles); end
      checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL unhold_release: got %0b expected 0", stall); end
      @(negedge clk);
      set_op(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 3'd3);
      id_kill = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL kill_stall: got %0b expected 0", stall); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (busy !== '0) begin fails++; $display("[TB] FAIL kill_busy: got %0h expected 0", busy); end
   endtask

   // Rounds of lat-4 producer + dependent consumer, 3 stalls each.
   task automatic test_saturation();
      int exp_main;
      int exp_sat;
      exp_main = 0;
      exp_sat  = 0;
      rst = 1'b1;
      #1 rst = 1'b0;
      for (int rnd = 1; rnd <= 7; rnd++) begin
         set_op(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 3'd4);
         @(negedge clk);
         set_op(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0);
         repeat (3) @(negedge clk);
         exp_main = exp_main + 3;
         exp_sat  = (exp_sat + 3 > 15) ? 15 : exp_sat + 3;
         #1;
         checks++; if (stall_cycles !== 16'(exp_main)) begin fails++; $display("[TB] FAIL perf_main_r%0d: got %0d expected %0d", rnd, stall_cycles, exp_main); end
         checks++; if (stall_cycles_s !== 4'(exp_sat)) begin fails++; $display("[TB] FAIL perf_sat_r%0d: got %0d expected %0d", rnd, stall_cycles_s, exp_sat); end
      end
      idle();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_load_use();
      test_branch();
      test_waw_r0();
      test_hold_kill();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
